// File: rtl/mac_pipe_pkg.sv
// mac_pipe_pkg: shared constants and helpers for the mac_pipe multiply-accumulate block.
//   - default operand/result widths
//   - legal range of extra output retiming stages
//   - addend selection encoding used by the stage-2 adder
//   - latency(): in_valid -> out_valid latency in cycles for a given stage count
package mac_pipe_pkg;

    localparam int DEF_A_W         = 4;
    localparam int DEF_B_W         = 4;
    localparam int DEF_C_W         = 4;
    localparam int DEF_OUT_W       = 8;
    localparam int DEF_PIPE_STAGES = 1;

    localparam int PIPE_STAGES_MIN = 0;
    localparam int PIPE_STAGES_MAX = 4;

    typedef enum logic [1:0] {
        AddC,
        AddAcc,
        AddZero
    } addend_sel_e;

    function automatic int latency(input int pipe_stages);
        return 2 + pipe_stages;
    endfunction

endpackage

// File: rtl/mac_pipe_dly.sv
// mac_pipe_dly: valid/data delay line of DEPTH registers (DEPTH = 0 is a pass-through).
// Data registers load only when their incoming valid is set, so the output data holds
// its last value while out_valid is low.
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset, clears valid and data
//   in_valid  in   incoming qualifier
//   in_data   in   W-bit incoming payload
//   out_valid out  qualifier delayed by DEPTH cycles
//   out_data  out  payload delayed by DEPTH cycles
module mac_pipe_dly
    import mac_pipe_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    if (DEPTH < PIPE_STAGES_MIN || DEPTH > PIPE_STAGES_MAX) begin : gen_bad_depth
        $error("mac_pipe_dly: DEPTH out of range 0..4");
    end

    if (DEPTH == 0) begin : gen_pass
        assign out_valid = in_valid;
        assign out_data  = in_data;
    end else begin : gen_regs
        logic [DEPTH-1:0]        valid_q;
        logic [DEPTH-1:0][W-1:0] data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= '0;
                data_q  <= '0;
            end else begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= in_data;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end

        assign out_valid = valid_q[DEPTH-1];
        assign out_data  = data_q[DEPTH-1];
    end

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: pipelined multiply-add / multiply-accumulate unit, one beat per cycle.
//   r = a*b + c              (acc_en = 0)
//   r = a*b + accumulator    (acc_en = 1, acc_clr = 0)
//   r = a*b                  (acc_en = 1, acc_clr = 1, restarts accumulation)
// acc_clr with in_valid = 0 clears the accumulator without producing a result.
// Stage 1 registers the inputs, stage 2 computes and holds the accumulator, then
// PIPE_STAGES retiming registers follow; latency is 2 + PIPE_STAGES cycles.
// Build option: define MAC_PIPE_SAT_EN to saturate overflowing results to all-ones
// (default build wraps modulo 2^OUT_W). ovf flags overflow in both builds.
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   in_valid  in   input beat qualifier
//   a, b, c   in   unsigned operands (A_W, B_W, C_W bits)
//   acc_en    in   accumulate mode select, sampled with in_valid
//   acc_clr   in   restart accumulation
//   out_valid out  result qualifier
//   r         out  OUT_W-bit result, holds while out_valid = 0
//   ovf       out  overflow flag for the result, holds while out_valid = 0
module mac_pipe
    import mac_pipe_pkg::*;
#(
    parameter int A_W         = DEF_A_W,
    parameter int B_W         = DEF_B_W,
    parameter int C_W         = DEF_C_W,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int PIPE_STAGES = DEF_PIPE_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic [C_W-1:0]   c,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    output logic [OUT_W-1:0] r,
    output logic             ovf
);

    localparam int P_W   = A_W + B_W;
    localparam int SUM_W = OUT_W + 1;

    if (OUT_W < A_W + B_W) begin : gen_bad_out_w_ab
        $error("mac_pipe: OUT_W must be at least A_W+B_W");
    end
    if (OUT_W < C_W) begin : gen_bad_out_w_c
        $error("mac_pipe: OUT_W must be at least C_W");
    end
    if (PIPE_STAGES < PIPE_STAGES_MIN || PIPE_STAGES > PIPE_STAGES_MAX) begin : gen_bad_stages
        $error("mac_pipe: PIPE_STAGES out of range 0..4");
    end

    // Stage 1: unconditional input capture.
    logic           v1_q;
    logic [A_W-1:0] a1_q;
    logic [B_W-1:0] b1_q;
    logic [C_W-1:0] c1_q;
    logic           acc_en1_q;
    logic           acc_clr1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            a1_q       <= '0;
            b1_q       <= '0;
            c1_q       <= '0;
            acc_en1_q  <= 1'b0;
            acc_clr1_q <= 1'b0;
        end else begin
            v1_q       <= in_valid;
            a1_q       <= a;
            b1_q       <= b;
            c1_q       <= c;
            acc_en1_q  <= acc_en;
            acc_clr1_q <= acc_clr;
        end
    end

    // Stage 2: multiply-add. acc_q feeds the next beat; res_q is the result copy that
    // must not see a standalone clear, so r keeps holding the last delivered value.
    logic             v2_q;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] res_q;
    logic             ovf2_q;

    addend_sel_e      addend_sel;
    logic [OUT_W-1:0] addend;
    logic [P_W-1:0]   prod;
    logic [SUM_W-1:0] sum;
    logic             sum_ovf;
    logic [OUT_W-1:0] sum_res;

    always_comb begin
        addend_sel = AddC;
        if (acc_en1_q) begin
            addend_sel = acc_clr1_q ? AddZero : AddAcc;
        end

        addend = '0;
        case (addend_sel)
            AddC:    addend = OUT_W'(c1_q);
            AddAcc:  addend = acc_q;
            AddZero: addend = '0;
            default: addend = '0;
        endcase

        prod    = {{B_W{1'b0}}, a1_q} * {{A_W{1'b0}}, b1_q};
        sum     = SUM_W'(prod) + SUM_W'(addend);
        // prod < 2^OUT_W and addend < 2^OUT_W, so the carry bit is exact overflow.
        sum_ovf = sum[OUT_W];
`ifdef MAC_PIPE_SAT_EN
        sum_res = sum_ovf ? '1 : sum[OUT_W-1:0];
`else
        sum_res = sum[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q   <= 1'b0;
            acc_q  <= '0;
            res_q  <= '0;
            ovf2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                acc_q  <= sum_res;
                res_q  <= sum_res;
                ovf2_q <= sum_ovf;
            end else if (acc_clr1_q) begin
                acc_q <= '0;
            end
        end
    end

    // Output retiming.
    logic [OUT_W:0] dly_data;

    mac_pipe_dly #(
        .DEPTH (PIPE_STAGES),
        .W     (OUT_W + 1)
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v2_q),
        .in_data   ({ovf2_q, res_q}),
        .out_valid (out_valid),
        .out_data  (dly_data)
    );

    assign r   = dly_data[OUT_W-1:0];
    assign ovf = dly_data[OUT_W];

endmodule

// File: tb/tb_mac_pipe.sv
module tb_mac_pipe;

    localparam int MAXV = 255;
    localparam int HIST = 4096;
`ifdef MAC_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic       acc_en;
    logic       acc_clr;

    // index 0: PIPE_STAGES=1, 1: PIPE_STAGES=0, 2: PIPE_STAGES=4
    logic       ov [3];
    logic [7:0] rv [3];
    logic       fv [3];

    mac_pipe u_dut_p1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov[0]), .r(rv[0]), .ovf(fv[0])
    );
    mac_pipe #(.PIPE_STAGES(0)) u_dut_p0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov[1]), .r(rv[1]), .ovf(fv[1])
    );
    mac_pipe #(.PIPE_STAGES(4)) u_dut_p4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov[2]), .r(rv[2]), .ovf(fv[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        case (d)
            0:       return 3;
            1:       return 2;
            default: return 6;
        endcase
    endfunction

    // Reference model: beats in issue order with plain arithmetic; results are
    // logged by the clock edge that accepted the beat and expected L-1 edges later.
    int acc_m    = 0;
    int n_edge   = 0;
    int rst_edge = 0;
    bit hv [HIST];
    int hr [HIST];
    bit ho [HIST];
    int last_r [3];
    bit last_o [3];

    always @(posedge clk) begin
        int addend;
        int sum;
        int res;
        bit o;
        n_edge++;
        if (rst) begin
            rst_edge = n_edge;
            acc_m    = 0;
        end else if (in_valid) begin
            if (!acc_en)      addend = int'(c);
            else if (acc_clr) addend = 0;
            else              addend = acc_m;
            sum = int'(a) * int'(b) + addend;
            o   = (sum > MAXV);
            res = o ? (SAT ? MAXV : sum % (MAXV + 1)) : sum;
            acc_m = res;
            if (n_edge < HIST) begin
                hv[n_edge] = 1'b1;
                hr[n_edge] = res;
                ho[n_edge] = o;
            end
        end else if (acc_clr) begin
            acc_m = 0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            int idx;
            bit ev;
            idx = n_edge - lat_of(d) + 1;
            ev  = 1'b0;
            if (rst) begin
                last_r[d] = 0;
                last_o[d] = 1'b0;
            end else if (idx > rst_edge && idx >= 1 && idx < HIST && hv[idx]) begin
                ev        = 1'b1;
                last_r[d] = hr[idx];
                last_o[d] = ho[idx];
            end
            check($sformatf("sb_valid[%0d]", d), int'(ov[d]), int'(ev));
            check($sformatf("sb_r[%0d]", d), int'(rv[d]), last_r[d]);
            check($sformatf("sb_ovf[%0d]", d), int'(fv[d]), int'(last_o[d]));
        end
    end

    task automatic drive(input bit v, input int aa, input int bb, input int cc,
                         input bit en, input bit clr);
        @(negedge clk);
        in_valid = v;
        a        = 4'(aa);
        b        = 4'(bb);
        c        = 4'(cc);
        acc_en   = en;
        acc_clr  = clr;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    // Bounded wait for the PIPE_STAGES=1 instance to present a result.
    task automatic wait_out(output bit ok, output int got_r, output bit got_o);
        ok    = 1'b0;
        got_r = -1;
        got_o = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (ov[0]) begin
                ok    = 1'b1;
                got_r = int'(rv[0]);
                got_o = fv[0];
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        int a;
        int b;
        int c;
        bit en;
        bit clr;
        int r_wrap;
        int r_sat;
        bit ovf;
    } vec_t;

    vec_t tbl [11];

    initial begin
        bit ok;
        int gr;
        bit go;
        bit seen;
        int lat_seen [3];

        tbl[0]  = '{15, 15, 15, 1'b0, 1'b0, 240, 240, 1'b0};
        tbl[1]  = '{3,  4,  0,  1'b1, 1'b1, 12,  12,  1'b0};
        tbl[2]  = '{3,  4,  0,  1'b1, 1'b0, 24,  24,  1'b0};
        tbl[3]  = '{3,  4,  0,  1'b1, 1'b0, 36,  36,  1'b0};
        tbl[4]  = '{15, 15, 0,  1'b1, 1'b1, 225, 225, 1'b0};
        tbl[5]  = '{15, 15, 0,  1'b1, 1'b0, 194, 255, 1'b1};
        tbl[6]  = '{0,  0,  7,  1'b0, 1'b0, 7,   7,   1'b0};
        tbl[7]  = '{1,  1,  0,  1'b1, 1'b0, 8,   8,   1'b0};
        tbl[8]  = '{15, 15, 15, 1'b0, 1'b1, 240, 240, 1'b0};
        tbl[9]  = '{2,  3,  0,  1'b1, 1'b0, 246, 246, 1'b0};
        tbl[10] = '{1,  10, 0,  1'b1, 1'b0, 0,   255, 1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        c        = '0;
        acc_en   = 1'b0;
        acc_clr  = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_valid[%0d]", d), int'(ov[d]), 0);
            check($sformatf("reset_r[%0d]", d), int'(rv[d]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Isolated single beats from the table.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].en, tbl[i].clr);
            idle();
            wait_out(ok, gr, go);
            check($sformatf("tbl%0d_valid", i), int'(ok), 1);
            if (ok) begin
                check($sformatf("tbl%0d_r", i), gr, SAT ? tbl[i].r_sat : tbl[i].r_wrap);
                check($sformatf("tbl%0d_ovf", i), int'(go), int'(tbl[i].ovf));
            end
        end

        // Back-to-back accumulation after a clear: 12, 24, 36 on consecutive cycles.
        drive(1'b1, 3, 4, 0, 1'b1, 1'b1);
        drive(1'b1, 3, 4, 0, 1'b1, 1'b0);
        drive(1'b1, 3, 4, 0, 1'b1, 1'b0);
        idle();
        wait_out(ok, gr, go);
        check("b2b_valid0", int'(ok), 1);
        check("b2b_r0", gr, 12);
        @(posedge clk);
        #1;
        check("b2b_valid1", int'(ov[0]), 1);
        check("b2b_r1", int'(rv[0]), 24);
        @(posedge clk);
        #1;
        check("b2b_valid2", int'(ov[0]), 1);
        check("b2b_r2", int'(rv[0]), 36);

        // Standalone clear between accumulations.
        drive(1'b1, 3, 4, 0, 1'b1, 1'b1);
        idle();
        wait_out(ok, gr, go);
        check("sclr_pre_r", gr, 12);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
        idle();
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            seen |= ov[0];
        end
        check("sclr_no_valid", int'(seen), 0);
        check("sclr_r_hold", int'(rv[0]), 12);
        drive(1'b1, 3, 4, 0, 1'b1, 1'b0);
        idle();
        wait_out(ok, gr, go);
        check("sclr_post_r", gr, 12);

        // Reset with two beats in flight.
        drive(1'b1, 5, 5, 0, 1'b1, 1'b0);
        drive(1'b1, 2, 2, 0, 1'b1, 1'b0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) seen |= ov[d];
        end
        check("rst_no_valid", int'(seen), 0);
        check("rst_r", int'(rv[0]), 0);
        drive(1'b1, 3, 4, 0, 1'b1, 1'b0);
        idle();
        wait_out(ok, gr, go);
        check("rst_acc_zero_r", gr, 12);

        // Latency of each instance.
        repeat (8) idle();
        drive(1'b1, 15, 15, 15, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) lat_seen[d] = -1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) in_valid = 1'b0;
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && lat_seen[d] < 0) begin
                    lat_seen[d] = e;
                    check($sformatf("lat_r[%0d]", d), int'(rv[d]), 240);
                end
            end
        end
        check("lat_p1", lat_seen[0], 3);
        check("lat_p0", lat_seen[1], 2);
        check("lat_p4", lat_seen[2], 6);

        // Randomized traffic, including a reset mid-stream; the model checks every cycle.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == 200) rst = 1'b1;
            if (i == 203) rst = 1'b0;
            in_valid = ($urandom_range(0, 3) != 0);
            a        = 4'($urandom);
            b        = 4'($urandom);
            c        = 4'($urandom);
            acc_en   = 1'($urandom_range(0, 1));
            acc_clr  = ($urandom_range(0, 7) == 0);
        end
        repeat (10) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
